// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide UART transmitter between NUM_REQ 16-bit word producers.
// Optional header byte per frame when UART_TX_SCHED_HEADER_EN is defined.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 100,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic                   frame_err,
    output logic                   active
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [16:0] GAP_LIM   = 17'(MIN_GAP);
    localparam logic [16:0] ABORT_LIM = 17'(MIN_GAP + TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_WAIT
`ifdef UART_TX_SCHED_HEADER_EN
        ,
        ST_HDR,
        ST_HDR_WAIT
`endif
    } state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   win_reg;
    logic [15:0]        timer_reg;
    logic [15:0]        word_q_reg;
    logic               byte_idx_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [7:0]         tx_data_reg;
    logic               tx_send_reg;
    logic               frame_err_reg;

    logic [15:0]        words [NUM_REQ];
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    logic               found;
    logic [16:0]        elapsed;
    logic               gap_ok;
    logic               abort;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign words[gi] = req_data[16*gi +: 16];
        end
    endgenerate

    // First requester found searching upward from the one after the last winner.
    always_comb begin
        pick  = rr_ptr_reg;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // The timer restarts on entry to a wait state, one cycle after the pulse,
    // so elapsed counts cycles since the tx_send pulse itself.
    assign elapsed = {1'b0, timer_reg} + 17'd1;
    assign gap_ok  = (elapsed >= GAP_LIM) && !tx_busy;
    assign abort   = (elapsed >= ABORT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= PTR_W'(NUM_REQ - 1);
            win_reg       <= '0;
            timer_reg     <= '0;
            word_q_reg    <= '0;
            byte_idx_reg  <= 1'b0;
            grant_reg     <= '0;
            tx_data_reg   <= '0;
            tx_send_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            grant_reg     <= '0;
            tx_send_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            timer_reg     <= (timer_reg == 16'hFFFF) ? timer_reg : timer_reg + 16'd1;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        win_reg   <= pick;
                        state_reg <= ST_GRANT;
                        timer_reg <= '0;
                    end
                end
                ST_GRANT: begin
                    grant_reg    <= NUM_REQ'(1) << win_reg;
                    word_q_reg   <= words[win_reg];
                    rr_ptr_reg   <= win_reg;
                    byte_idx_reg <= 1'b0;
                    timer_reg    <= '0;
`ifdef UART_TX_SCHED_HEADER_EN
                    state_reg    <= ST_HDR;
`else
                    state_reg    <= ST_SEND;
`endif
                end
`ifdef UART_TX_SCHED_HEADER_EN
                ST_HDR: begin
                    tx_send_reg <= 1'b1;
                    tx_data_reg <= {4'hA, 1'b0, 3'(win_reg)};
                    state_reg   <= ST_HDR_WAIT;
                    timer_reg   <= '0;
                end
                ST_HDR_WAIT: begin
                    if (gap_ok) begin
                        state_reg <= ST_SEND;
                        timer_reg <= '0;
                    end else if (abort) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                        timer_reg     <= '0;
                    end
                end
`endif
                ST_SEND: begin
                    tx_send_reg <= 1'b1;
                    tx_data_reg <= byte_idx_reg ? word_q_reg[7:0] : word_q_reg[15:8];
                    state_reg   <= ST_WAIT;
                    timer_reg   <= '0;
                end
                ST_WAIT: begin
                    if (gap_ok) begin
                        timer_reg <= '0;
                        if (!byte_idx_reg) begin
                            byte_idx_reg <= 1'b1;
                            state_reg    <= ST_SEND;
                        end else begin
                            state_reg    <= ST_IDLE;
                        end
                    end else if (abort) begin
                        // Remaining bytes are dropped; rr_ptr already moved past this requester.
                        frame_err_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                        timer_reg     <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    timer_reg <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign tx_data   = tx_data_reg;
    assign tx_send   = tx_send_reg;
    assign frame_err = frame_err_reg;
    assign active    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, corner-case sequences and randomized frames
// checked against a round-robin/pacing reference model with a simple UART busy model.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ = 4;
    localparam int MIN_GAP = 100;
    localparam int TIMEOUT = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic        frame_err;
    logic        active;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int viol = 0;
    int busy_len = 0;
    int busy_cnt = 0;

    uart_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_busy   (tx_busy),
        .frame_err (frame_err),
        .active    (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for busy_len cycles after each tx_send; also watch pulse exclusivity.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else if (tx_send) begin
            busy_cnt = busy_len;
            tx_busy  = (busy_len > 0);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (!reset && ((int'(grant != 0) + int'(tx_send) + int'(frame_err) > 1) ||
                       ((grant & (grant - 4'd1)) != 0)))
            viol++;
    end

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        int          busy;
        logic [3:0]  eg;
        logic [7:0]  e0;
        logic [7:0]  e1;
        int          gap;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic wait_grant(output logic [3:0] g, output int t, input int budget);
        g = '0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                g = grant;
                t = cyc;
                return;
            end
        end
        expired("wait_grant");
    endtask

    task automatic wait_send(output logic [7:0] b, output int t, input int budget);
        b = '0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_send) begin
                b = tx_data;
                t = cyc;
                return;
            end
        end
        expired("wait_send");
    endtask

    task automatic wait_ferr(output int t, output int sends, input int budget);
        t = -1;
        sends = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_send) sends++;
            if (frame_err) begin
                t = cyc;
                return;
            end
        end
        expired("wait_frame_err");
    endtask

    task automatic wait_idle(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!active) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        busy_len = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame: grant, optional header, two data bytes with the expected pacing.
    task automatic run_frame(input string tag, input logic [3:0] eg, input logic [7:0] e0,
                             input logic [7:0] e1, input int egap, input int t_ref,
                             input bit drop, output int t_first);
        logic [3:0] g;
        logic [7:0] b;
        int tg, t1, t2;
        wait_grant(g, tg, 30000);
        if (drop) req = '0;
        check({tag, " grant"}, g, eg);
        if (t_ref >= 0) check({tag, " grant_latency"}, tg - t_ref, 2);
`ifdef UART_TX_SCHED_HEADER_EN
        wait_send(b, t_first, 30000);
        check({tag, " header"}, b, {4'hA, 1'b0, 3'(onehot_idx(eg))});
        wait_send(b, t1, 30000);
        check({tag, " hdr_gap"}, t1 - t_first, egap);
`else
        wait_send(b, t1, 30000);
        t_first = t1;
`endif
        check({tag, " byte0"}, b, e0);
        if (t_ref >= 0) check({tag, " send_latency"}, t_first - t_ref, 3);
        wait_send(b, t2, 30000);
        check({tag, " byte1"}, b, e1);
        check({tag, " byte_gap"}, t2 - t1, egap);
    endtask

    vec_t vecs [6];

    initial begin
        bit ok;
        int t0, tf, prev, tg, t1, sends, last, exp_w, blen, egap;
        logic [3:0] g, mask;
        logic [7:0] b;
        logic [15:0] word;

        vecs[0] = '{req: 4'b0010, data: {16'h0000, 16'h0000, 16'hBEEF, 16'h0000}, busy: 0,
                    eg: 4'b0010, e0: 8'hBE, e1: 8'hEF, gap: 101};
        vecs[1] = '{req: 4'b1000, data: {16'h1234, 16'hAAAA, 16'hBBBB, 16'hCCCC}, busy: 0,
                    eg: 4'b1000, e0: 8'h12, e1: 8'h34, gap: 101};
        vecs[2] = '{req: 4'b0110, data: {16'h1111, 16'h5A5A, 16'hC3C4, 16'h2222}, busy: 500,
                    eg: 4'b0010, e0: 8'hC3, e1: 8'hC4, gap: 502};
        vecs[3] = '{req: 4'b1111, data: {16'h3333, 16'h4444, 16'h5555, 16'h8001}, busy: 50,
                    eg: 4'b0001, e0: 8'h80, e1: 8'h01, gap: 101};
        vecs[4] = '{req: 4'b1100, data: {16'h6666, 16'hDEAD, 16'h7777, 16'h8888}, busy: 99,
                    eg: 4'b0100, e0: 8'hDE, e1: 8'hAD, gap: 101};
        vecs[5] = '{req: 4'b1010, data: {16'h9999, 16'hABCD, 16'h7E01, 16'hEEEE}, busy: 100,
                    eg: 4'b0010, e0: 8'h7E, e1: 8'h01, gap: 102};

        do_reset();
        check("reset grant", grant, 0);
        check("reset tx_send", tx_send, 0);
        check("reset frame_err", frame_err, 0);
        check("reset tx_data", tx_data, 0);
        check("reset active", active, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            req_data = vecs[v].data;
            busy_len = vecs[v].busy;
            req      = vecs[v].req;
            t0       = cyc;
            run_frame($sformatf("vec%0d", v), vecs[v].eg, vecs[v].e0, vecs[v].e1,
                      vecs[v].gap, t0, 1'b1, tf);
            wait_idle(ok, 2000);
            check($sformatf("vec%0d idle", v), ok, 1);
            check($sformatf("vec%0d tx_data_hold", v), tx_data, vecs[v].e1);
        end

        // All four requesting continuously: strict rotation, then wrap to 0.
        do_reset();
        req_data = {16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
        req      = 4'hF;
        t0       = cyc;
        prev     = 0;
        for (int f = 0; f < 4; f++) begin
            word = req_data[16*f +: 16];
            run_frame($sformatf("rr%0d", f), 4'(1 << f), word[15:8], word[7:0], 101,
                      (f == 0) ? t0 : -1, 1'b0, tf);
            if (f > 0) check($sformatf("rr%0d spacing_ok", f), (tf - prev) >= MIN_GAP + 2, 1);
            prev = tf;
        end
        wait_grant(g, tg, 2000);
        check("rr wrap_grant", g, 4'b0001);
        req = '0;
        wait_idle(ok, 2000);
        check("rr idle", ok, 1);

        // tx_busy stuck: abort after MIN_GAP+TIMEOUT, then the next requester is served.
        do_reset();
        req_data = {16'h0000, 16'h0000, 16'h2468, 16'h1357};
        busy_len = 30000;
        req      = 4'b0011;
        wait_grant(g, tg, 100);
        check("stuck grant", g, 4'b0001);
        wait_send(b, t1, 100);
        wait_ferr(tf, sends, 25000);
        check("stuck err_time", tf - t1, MIN_GAP + TIMEOUT);
        check("stuck no_extra_send", sends, 0);
        busy_len = 0;
        wait_grant(g, tg, 100);
        req = '0;
        check("stuck next_grant", g, 4'b0010);
        check("stuck next_latency", tg - tf, 2);
        wait_send(b, t1, 100);
        check("stuck next_send_latency", t1 - tg, 1);
        wait_idle(ok, 2000);
        check("stuck idle", ok, 1);

        // Reset in WAIT after the first byte.
        do_reset();
        req_data = {16'h0000, 16'h0000, 16'hFFFF, 16'hC0DE};
        req      = 4'b0001;
        wait_grant(g, tg, 100);
        wait_send(b, t1, 100);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset grant", grant, 0);
        check("midreset tx_send", tx_send, 0);
        check("midreset frame_err", frame_err, 0);
        check("midreset tx_data", tx_data, 0);
        check("midreset active", active, 0);
        req = 4'b0011;
        @(negedge clk);
        reset = 1'b0;
        t0    = cyc;
        wait_grant(g, tg, 100);
        req = '0;
        check("midreset first_grant", g, 4'b0001);
        check("midreset grant_latency", tg - t0, 2);
        wait_idle(ok, 2000);
        check("midreset idle", ok, 1);

        // Randomized frames against the round-robin / pacing model.
        do_reset();
        last = NUM_REQ - 1;
        for (int r = 0; r < 25; r++) begin
            mask     = 4'($urandom_range(1, 15));
            req_data = {$urandom, $urandom};
            blen     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 200));
            exp_w    = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (exp_w < 0 && mask[(last + k) % NUM_REQ]) exp_w = (last + k) % NUM_REQ;
            word     = req_data[16*exp_w +: 16];
            egap     = ((blen + 1 > MIN_GAP) ? blen + 1 : MIN_GAP) + 1;
            busy_len = blen;
            req      = mask;
            t0       = cyc;
            run_frame($sformatf("rnd%0d", r), 4'(1 << exp_w), word[15:8], word[7:0],
                      egap, t0, 1'b1, tf);
            last = exp_w;
            wait_idle(ok, 2000);
            check($sformatf("rnd%0d idle", r), ok, 1);
            check($sformatf("rnd%0d tx_data_hold", r), tx_data, word[7:0]);
        end

        check("pulse_exclusive_onehot", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
